// File: rtl/bus_cdc_responder.sv
// bus_cdc_responder: destination-domain endpoint behind a busy-enabled bus CDC.
// Decodes single-cycle pulsed requests and serves them from a local register bank
// (reg 0 = sticky status, W1C) or a variable-latency backend port. Each accepted
// transaction produces exactly one busy pulse; its falling edge marks data_o valid.
// Optional feature: define RESPONDER_TIMEOUT_EN to abort backend accesses that are
// not acknowledged within TimeoutCycles (data_o = all ones, status bit0 set).
module bus_cdc_responder #(
  parameter logic [31:0] BaseAddress   = 32'h0000_9000,
  parameter int          NumLocalRegs  = 4,
  parameter logic [31:0] BackendOffset = 32'h0000_0100,
  parameter logic [31:0] BackendSize   = 32'h0000_0100,
  parameter logic [31:0] WindowSize    = 32'h0000_0200,
  parameter int          TimeoutCycles = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] address_i,
  input  logic [31:0] data_i,
  input  logic        we_i,
  input  logic [3:0]  we_ram_i,
  output logic [31:0] data_o,
  output logic        busy_o,
  output logic        bk_req_o,
  output logic        bk_we_o,
  output logic [31:0] bk_addr_o,
  output logic [31:0] bk_wdata_o,
  output logic [3:0]  bk_be_o,
  input  logic        bk_ack_i,
  input  logic [31:0] bk_rdata_i
);

  localparam logic [31:0] LocalSize = 32'(NumLocalRegs * 4);
  localparam int          IdxW      = $clog2(NumLocalRegs);

  typedef enum logic [1:0] {IDLE, LOCAL, BK_WAIT, DONE} state_t;

  state_t state, state_next;

  logic [31:0]     offset;
  logic            in_window, local_hit, bk_hit;
  logic            accept, overrun_evt, timeout_evt;
  logic [3:0]      be_eff;
  logic            cap_we, cap_unmapped;
  logic [31:0]     cap_wdata;
  logic [3:0]      cap_be;
  logic [IdxW-1:0] cap_idx;
  logic [2:0]      status, status_set, status_clr;
  logic [31:0]     rd_val;
  logic            local_wr;
  logic [31:0]     scratch [1:NumLocalRegs-1];

  // Address decode; a request arriving with an ack, or outside IDLE, is an overrun.
  always_comb begin
    offset      = address_i - BaseAddress;
    in_window   = (address_i >= BaseAddress) && (offset < WindowSize);
    local_hit   = offset < LocalSize;
    bk_hit      = !local_hit && (offset >= BackendOffset) &&
                  (offset < BackendOffset + BackendSize);
    accept      = in_window && (state == IDLE) && !bk_ack_i;
    overrun_evt = in_window && !accept;
    be_eff      = (we_i && (we_ram_i == 4'h0)) ? 4'hF : we_ram_i;
  end

`ifdef RESPONDER_TIMEOUT_EN
  logic [7:0] bk_cnt;

  // Cycles spent in BK_WAIT without an ack; restarts from 0 on every request.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      bk_cnt <= '0;
    else if (accept)
      bk_cnt <= '0;
    else if ((state == BK_WAIT) && !bk_ack_i && !timeout_evt)
      bk_cnt <= bk_cnt + 8'd1;
  end

  // Give up on the backend once the counter reaches the limit with no ack.
  always_comb timeout_evt = (state == BK_WAIT) && !bk_ack_i &&
                            (bk_cnt == 8'(TimeoutCycles));
`else
  logic [7:0] unused_timeout_limit;

  // TimeoutCycles has no effect in this build: the backend wait is unbounded.
  always_comb begin
    timeout_evt          = 1'b0;
    unused_timeout_limit = 8'(TimeoutCycles);
  end
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic; unmapped offsets are completed through LOCAL.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = bk_hit ? BK_WAIT : LOCAL;
      LOCAL:   state_next = DONE;
      BK_WAIT: if (bk_ack_i || timeout_evt) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Local read mux plus status set/clear terms.
  always_comb begin
    rd_val     = (cap_idx == '0) ? {29'd0, status} : scratch[cap_idx];
    local_wr   = (state == LOCAL) && !cap_unmapped && cap_we;
    status_set = {overrun_evt, (state == LOCAL) && cap_unmapped, timeout_evt};
    status_clr = (local_wr && (cap_idx == '0) && cap_be[0]) ? cap_wdata[2:0] : 3'b0;
  end

  // Sticky status bits; a set in the same cycle as a clear wins.
  always_ff @(posedge clk_i) begin
    if (reset_i) status <= '0;
    else         status <= (status & ~status_clr) | status_set;
  end

  // Request capture, busy/backend handshake and return data.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_o       <= '0;
      busy_o       <= 1'b0;
      bk_req_o     <= 1'b0;
      bk_we_o      <= 1'b0;
      bk_addr_o    <= '0;
      bk_wdata_o   <= '0;
      bk_be_o      <= '0;
      cap_we       <= 1'b0;
      cap_unmapped <= 1'b0;
      cap_wdata    <= '0;
      cap_be       <= '0;
      cap_idx      <= '0;
      for (int i = 1; i < NumLocalRegs; i++) scratch[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            busy_o       <= 1'b1;
            cap_we       <= we_i;
            cap_wdata    <= data_i;
            cap_be       <= be_eff;
            cap_idx      <= offset[IdxW+1:2];
            cap_unmapped <= !local_hit && !bk_hit;
            if (bk_hit) begin
              bk_req_o   <= 1'b1;
              bk_we_o    <= we_i;
              bk_addr_o  <= offset - BackendOffset;
              bk_wdata_o <= data_i;
              bk_be_o    <= be_eff;
            end
          end
        end
        LOCAL: begin
          busy_o <= 1'b0;
          if (cap_unmapped || cap_we) data_o <= '0;
          else                        data_o <= rd_val;
          if (local_wr && (cap_idx != '0)) begin
            for (int b = 0; b < 4; b++)
              if (cap_be[b]) scratch[cap_idx][b*8 +: 8] <= cap_wdata[b*8 +: 8];
          end
        end
        BK_WAIT: begin
          if (bk_ack_i) begin
            bk_req_o <= 1'b0;
            busy_o   <= 1'b0;
            data_o   <= bk_we_o ? 32'd0 : bk_rdata_i;
          end else if (timeout_evt) begin
            bk_req_o <= 1'b0;
            busy_o   <= 1'b0;
            data_o   <= 32'hFFFF_FFFF;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cdc_responder.sv
// tb_bus_cdc_responder: directed self-checking bench for bus_cdc_responder.
// Covers local scratch/status access, byte enables, backend handshake, overrun,
// stray acks, timeout (RESPONDER_TIMEOUT_EN) and reset during a backend wait.
module tb_bus_cdc_responder;

  logic        clk_i;
  logic        reset_i;
  logic [31:0] address_i;
  logic [31:0] data_i;
  logic        we_i;
  logic [3:0]  we_ram_i;
  logic [31:0] data_o;
  logic        busy_o;
  logic        bk_req_o;
  logic        bk_we_o;
  logic [31:0] bk_addr_o;
  logic [31:0] bk_wdata_o;
  logic [3:0]  bk_be_o;
  logic        bk_ack_i;
  logic [31:0] bk_rdata_i;

  int n_checks = 0;
  int n_errors = 0;
  int req_cycles;
  int busy_cycles;

  bus_cdc_responder dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .address_i  (address_i),
    .data_i     (data_i),
    .we_i       (we_i),
    .we_ram_i   (we_ram_i),
    .data_o     (data_o),
    .busy_o     (busy_o),
    .bk_req_o   (bk_req_o),
    .bk_we_o    (bk_we_o),
    .bk_addr_o  (bk_addr_o),
    .bk_wdata_o (bk_wdata_o),
    .bk_be_o    (bk_be_o),
    .bk_ack_i   (bk_ack_i),
    .bk_rdata_i (bk_rdata_i)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Advance to 1 ns after the next rising edge, where outputs are settled.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Pulse one request for a single cycle starting in the current cycle.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic we, input logic [3:0] be);
    address_i = addr;
    data_i    = data;
    we_i      = we;
    we_ram_i  = be;
    tick();
    address_i = '0;
    data_i    = '0;
    we_i      = 1'b0;
    we_ram_i  = '0;
  endtask

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  // One local access: busy high for exactly one cycle, then data held after the fall.
  task automatic localAccess(input string tag, input logic [31:0] addr,
                             input logic [31:0] data, input logic we,
                             input logic [3:0] be, input logic [31:0] exp_data);
    applyStimulus(addr, data, we, be);
    checkOutput({tag, "_busy_hi"}, 32'(busy_o), 32'd1);
    tick();
    checkOutput({tag, "_busy_lo"}, 32'(busy_o), 32'd0);
    if (!we) checkOutput({tag, "_data"}, data_o, exp_data);
    tick();
    if (!we) checkOutput({tag, "_hold"}, data_o, exp_data);
  endtask

  initial begin
    reset_i    = 1'b1;
    address_i  = '0;
    data_i     = '0;
    we_i       = 1'b0;
    we_ram_i   = '0;
    bk_ack_i   = 1'b0;
    bk_rdata_i = '0;
    repeat (3) tick();
    checkOutput("rst_busy",   32'(busy_o),   32'd0);
    checkOutput("rst_data",   data_o,        32'd0);
    checkOutput("rst_req",    32'(bk_req_o), 32'd0);
    checkOutput("rst_we",     32'(bk_we_o),  32'd0);
    checkOutput("rst_addr",   bk_addr_o,     32'd0);
    checkOutput("rst_wdata",  bk_wdata_o,    32'd0);
    checkOutput("rst_be",     32'(bk_be_o),  32'd0);
    reset_i = 1'b0;
    tick();

    // Scratch full-word write/read and byte-enable merge.
    localAccess("wr_r1",    32'h9004, 32'hA5A5_1234, 1'b1, 4'b0000, 32'h0);
    localAccess("rd_r1",    32'h9004, 32'h0,         1'b0, 4'b0000, 32'hA5A5_1234);
    localAccess("wr_r2_be", 32'h9008, 32'hFFFF_FFFF, 1'b1, 4'b0010, 32'h0);
    localAccess("rd_r2",    32'h9008, 32'h0,         1'b0, 4'b0000, 32'h0000_FF00);

    // Unmapped read, sticky status, W1C gated by byte 0 enable.
    localAccess("rd_unmap",   32'h9040, 32'h0, 1'b0, 4'b0000, 32'h0);
    localAccess("st_unmap",   32'h9000, 32'h0, 1'b0, 4'b0000, 32'h2);
    localAccess("st_wr_b1",   32'h9000, 32'hFFFF_FFFF, 1'b1, 4'b0010, 32'h0);
    localAccess("st_keep",    32'h9000, 32'h0, 1'b0, 4'b0000, 32'h2);
    localAccess("st_clr",     32'h9000, 32'h2, 1'b1, 4'b0000, 32'h0);
    localAccess("st_cleared", 32'h9000, 32'h0, 1'b0, 4'b0000, 32'h0);

    // Backend read, ack five cycles after the request rises.
    applyStimulus(32'h9104, 32'h0, 1'b0, 4'b0000);
    checkOutput("bk_rd_busy", 32'(busy_o),   32'd1);
    checkOutput("bk_rd_addr", bk_addr_o,     32'h4);
    checkOutput("bk_rd_we",   32'(bk_we_o),  32'd0);
    req_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      if (bk_req_o) req_cycles++;
      if (i == 5) begin
        bk_ack_i   = 1'b1;
        bk_rdata_i = 32'hCAFE_F00D;
      end
      tick();
    end
    bk_ack_i   = 1'b0;
    bk_rdata_i = '0;
    checkOutput("bk_rd_req_width", 32'(req_cycles), 32'd6);
    checkOutput("bk_rd_req_lo",    32'(bk_req_o),   32'd0);
    checkOutput("bk_rd_busy_lo",   32'(busy_o),     32'd0);
    checkOutput("bk_rd_data",      data_o,          32'hCAFE_F00D);
    tick();
    checkOutput("bk_rd_hold",      data_o,          32'hCAFE_F00D);

    // Backend write with a second request pulsed during BK_WAIT.
    applyStimulus(32'h9110, 32'h1122_3344, 1'b1, 4'b1100);
    checkOutput("bk_wr_addr",  bk_addr_o,    32'h10);
    checkOutput("bk_wr_we",    32'(bk_we_o), 32'd1);
    checkOutput("bk_wr_be",    32'(bk_be_o), 32'hC);
    checkOutput("bk_wr_wdata", bk_wdata_o,   32'h1122_3344);
    tick();
    applyStimulus(32'h9004, 32'h0, 1'b0, 4'b0000);
    checkOutput("ovr_busy", 32'(busy_o),   32'd1);
    checkOutput("ovr_req",  32'(bk_req_o), 32'd1);
    checkOutput("ovr_addr", bk_addr_o,     32'h10);
    bk_ack_i   = 1'b1;
    bk_rdata_i = 32'hDEAD_BEEF;
    tick();
    bk_ack_i   = 1'b0;
    bk_rdata_i = '0;
    checkOutput("bk_wr_busy_lo", 32'(busy_o),   32'd0);
    checkOutput("bk_wr_req_lo",  32'(bk_req_o), 32'd0);
    checkOutput("bk_wr_data",    data_o,        32'h0);
    tick();
    localAccess("st_ovr",     32'h9000, 32'h0, 1'b0, 4'b0000, 32'h4);
    localAccess("st_ovr_clr", 32'h9000, 32'h4, 1'b1, 4'b0001, 32'h0);

    // Ack in the same cycle the backend request first rises.
    applyStimulus(32'h9100, 32'h0, 1'b0, 4'b0000);
    checkOutput("fast_req", 32'(bk_req_o), 32'd1);
    bk_ack_i   = 1'b1;
    bk_rdata_i = 32'h1234_5678;
    tick();
    bk_ack_i   = 1'b0;
    bk_rdata_i = '0;
    checkOutput("fast_busy_lo", 32'(busy_o), 32'd0);
    checkOutput("fast_data",    data_o,      32'h1234_5678);
    tick();

    // Request together with a stray ack in IDLE: overrun, no transaction.
    bk_ack_i = 1'b1;
    applyStimulus(32'h9004, 32'h0, 1'b0, 4'b0000);
    bk_ack_i = 1'b0;
    checkOutput("stray_busy", 32'(busy_o), 32'd0);
    tick();
    checkOutput("stray_busy2", 32'(busy_o), 32'd0);
    localAccess("st_stray",     32'h9000, 32'h0, 1'b0, 4'b0000, 32'h4);
    localAccess("st_stray_clr", 32'h9000, 32'h7, 1'b1, 4'b0000, 32'h0);

`ifdef RESPONDER_TIMEOUT_EN
    // Unacknowledged backend read aborts after the timeout.
    applyStimulus(32'h9108, 32'h0, 1'b0, 4'b0000);
    busy_cycles = 0;
    while (busy_o && busy_cycles < 400) begin
      busy_cycles++;
      tick();
    end
    checkOutput("to_busy_lo", 32'(busy_o),   32'd0);
    checkOutput("to_req_lo",  32'(bk_req_o), 32'd0);
    checkOutput("to_data",    data_o,        32'hFFFF_FFFF);
    checkOutput("to_width", 32'(busy_cycles >= 255 && busy_cycles <= 257), 32'd1);
    tick();
    localAccess("st_to",      32'h9000, 32'h0, 1'b0, 4'b0000, 32'h1);
    localAccess("st_to_clr",  32'h9000, 32'h1, 1'b1, 4'b0001, 32'h0);
    localAccess("st_to_done", 32'h9000, 32'h0, 1'b0, 4'b0000, 32'h0);
`else
    // Without the timeout the backend wait never ends on its own.
    applyStimulus(32'h9108, 32'h0, 1'b0, 4'b0000);
    repeat (300) tick();
    checkOutput("nto_busy", 32'(busy_o),   32'd1);
    checkOutput("nto_req",  32'(bk_req_o), 32'd1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    checkOutput("nto_rst_busy", 32'(busy_o), 32'd0);
    tick();
    localAccess("st_nto", 32'h9000, 32'h0, 1'b0, 4'b0000, 32'h0);
`endif

    // Reset in BK_WAIT aborts silently and clears the scratch registers.
    localAccess("pre_rst_wr", 32'h9004, 32'h5555_AAAA, 1'b1, 4'b0000, 32'h0);
    applyStimulus(32'h9104, 32'h0, 1'b0, 4'b0000);
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    checkOutput("rst_bw_busy", 32'(busy_o),   32'd0);
    checkOutput("rst_bw_req",  32'(bk_req_o), 32'd0);
    tick();
    checkOutput("rst_bw_nopulse", 32'(busy_o), 32'd0);
    localAccess("rst_rd_r1",  32'h9004, 32'h0, 1'b0, 4'b0000, 32'h0);
    localAccess("rst_rd_r2",  32'h9008, 32'h0, 1'b0, 4'b0000, 32'h0);
    localAccess("post_wr_r3", 32'h900C, 32'h5A5A_5A5A, 1'b1, 4'b0000, 32'h0);
    localAccess("post_rd_r3", 32'h900C, 32'h0, 1'b0, 4'b0000, 32'h5A5A_5A5A);
    applyStimulus(32'h91FC, 32'h0, 1'b0, 4'b0000);
    checkOutput("post_bk_addr", bk_addr_o, 32'hFC);
    bk_ack_i   = 1'b1;
    bk_rdata_i = 32'h0BAD_CAFE;
    tick();
    bk_ack_i   = 1'b0;
    bk_rdata_i = '0;
    checkOutput("post_bk_busy", 32'(busy_o), 32'd0);
    checkOutput("post_bk_data", data_o,      32'h0BAD_CAFE);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_cdc_responder.md
# bus_cdc_responder

Module-side bus endpoint that sits in a destination clock domain behind a busy-enabled bus CDC entry. It decodes the single-cycle pulsed transactions that the CDC presents and serves them from a small local register bank or a variable-latency backend port. It signals completion with exactly one busy pulse per transaction, whose falling edge tells the CDC to capture the return data.

## Interface
Parameters:
- BaseAddress, 32'h0000_9000, byte address of window start; must be nonzero, since an all-zero bus means idle.
- NumLocalRegs, 4, number of 32-bit local registers (2..16) at offsets 0x0, 0x4, ...
- BackendOffset, 32'h100, byte offset of the backend window from BaseAddress.
- BackendSize, 32'h100, byte size of the backend window.
- WindowSize, 32'h200, total decoded window size; must cover both sub-windows.
- TimeoutCycles, 255, backend ack timeout (8-bit counter range).

Ports:
- clk_i  in  1  module-domain clock; the only clock.
- reset_i  in  1  synchronous, active-high reset.
- address_i  in  32  pulsed bus address; zero when idle.
- data_i  in  32  pulsed write data.
- we_i  in  1  pulsed write enable.
- we_ram_i  in  4  pulsed byte enables; 0 with we_i=1 means full word.
- data_o  out  32  read return data to the CDC.
- busy_o  out  1  transaction-in-progress; its falling edge marks data_o valid.
- bk_req_o  out  1  backend request, level, held until ack or timeout.
- bk_we_o  out  1  backend write.
- bk_addr_o  out  32  backend byte offset (address_i − BaseAddress − BackendOffset).
- bk_wdata_o  out  32  backend write data.
- bk_be_o  out  4  backend byte enables (4'hF for a full-word write, else we_ram_i).
- bk_ack_i  in  1  backend completion, 1-cycle pulse.
- bk_rdata_i  in  32  backend read data, valid with bk_ack_i.

## Operation
- **Request:** address_i in [BaseAddress, BaseAddress+WindowSize) in state IDLE. The request captures address, data, we and byte enables into registers.
- **FSM states:** IDLE, LOCAL, BK_WAIT, DONE.
- **IDLE:**
  - Local-window request goes to LOCAL.
  - Backend-window request goes to BK_WAIT.
  - Unmapped offset inside the window goes to LOCAL: read returns 0, write is dropped, status bit1 (unmapped) sets.
- **LOCAL:** performs the register write or read, then goes to DONE.
- **BK_WAIT:** holds bk_req_o=1 until bk_ack_i, then goes to DONE. On ack, bk_rdata_i is latched for reads and data_o is 0 for writes.
- **DONE:** deasserts busy_o, returns to IDLE.
- **Register 0, status:**
  - bit0: timeout, sticky.
  - bit1: unmapped, sticky.
  - bit2: overrun, sticky.
  - All other bits 0.
  - Writes clear bits where data is 1 (write-1-to-clear), qualified by byte 0 enable.
- **Registers 1..NumLocalRegs-1:** read/write scratch with byte-enable merge.
- **Request outside IDLE:** ignored, sets overrun; the in-flight transaction is unaffected.
- **Reads and writes alike:** both produce one busy pulse, because the CDC waits for a return on every transaction.

## Timing
- **Reset values:** data_o=0, busy_o=0, bk_req_o=0, bk_we_o=0, bk_addr_o=0, bk_wdata_o=0, bk_be_o=0, all registers 0, FSM in IDLE.
- **Local access:** request at cycle 0; busy_o=1 at cycle 1; busy_o=0 with data_o valid at cycle 2.
- **Backend access:**
  - bk_req_o and busy_o both rise at cycle 1.
  - bk_ack_i at cycle k (k≥1) drops bk_req_o at k+1.
  - busy_o falls at k+1, with data_o valid from k+1.
  - An ack in the same cycle bk_req_o first rises is legal.
- **Minimum busy width:** 1 cycle; busy_o never stays low between request and completion.
- **data_o hold:** data_o stays stable from the busy falling edge until the next accepted request, so the CDC capturing one cycle after the edge is safe.
- **Ack timing:** bk_ack_i outside BK_WAIT is ignored.
- **Request and ack in the same cycle:** the request is treated as overrun; no new transaction starts.
- **reset_i mid-transaction:** FSM returns to IDLE at the next edge and busy_o, bk_req_o go 0. No completion pulse is generated for the aborted access.

## Configuration
- **RESPONDER_TIMEOUT_EN defined:**
  - An 8-bit counter runs in BK_WAIT, starting from 0 on entry.
  - When it reaches TimeoutCycles with no ack, bk_req_o drops and data_o becomes 32'hFFFF_FFFF.
  - Status bit0 sets, and the FSM goes to DONE.
- **RESPONDER_TIMEOUT_EN undefined:** no counter; BK_WAIT waits indefinitely and status bit0 always reads 0.

## Test plan
- Reset, then write 32'hA5A5_1234 to BaseAddress+0x4, then read BaseAddress+0x4 -> each access gives busy high 1 cycle, then data_o=32'hA5A5_1234 from the busy fall.
- Write 32'hFFFF_FFFF to BaseAddress+0x8 with we_ram_i=4'b0010 over a zeroed register, then read -> data_o=32'h0000_FF00.
- Read BaseAddress+0x104 with bk_ack_i 5 cycles after bk_req_o and bk_rdata_i=32'hCAFE_F00D:
  - bk_addr_o=0x4 and bk_req_o high 6 cycles.
  - busy_o falls the cycle after the ack, with data_o=32'hCAFE_F00D.
- Backend read with no ack, TimeoutCycles=255:
  - With RESPONDER_TIMEOUT_EN: busy_o falls after the timeout, data_o=32'hFFFF_FFFF, and a status read gives bit0=1; writing 1 to bit0 clears it.
  - Without RESPONDER_TIMEOUT_EN: busy_o stays high.
- Read unmapped BaseAddress+0x40 -> data_o=0 and status bit1=1. Then pulse a second request during BK_WAIT -> status bit2=1 and the original transaction completes normally.
- Assert reset_i during BK_WAIT -> busy_o=0 and bk_req_o=0 next cycle, scratch registers read 0, and the next request is served normally.
